// File: rtl/plic_pkg.sv
// Shared types and defaults for the PLIC interrupt sequencer.
package plic_pkg;

    localparam logic [2:0]  CLAIM_ADDR_DEF = 3'd7;
    localparam int unsigned RD_LAT_DEF     = 1;
    localparam int unsigned ID_W_DEF       = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLAIM_ISSUE,
        CLAIM_WAIT,
        PRESENT,
        SERVICE,
        COMPLETE_WR,
        XFER_ISSUE,
        XFER_WAIT
    } plic_state_e;

endpackage

// File: rtl/plic_rd_timer.sv
// Read-latency down-counter: loaded on the strobe cycle, done_o marks the
// cycle in which the register port's read data is valid.
module plic_rd_timer #(
    parameter int unsigned LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic done_o
);

    // The strobe cycle itself accounts for one cycle of latency.
    localparam logic [1:0] LOAD_VAL = (LAT == 0) ? 2'd0 : 2'(LAT - 1);

    logic [1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 2'd1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/plic_irq_sequencer.sv
// Owns the interrupt controller's register port: claim, present to the trap
// unit, complete after mret, with CPU MMIO accesses interleaved.
module plic_irq_sequencer
    import plic_pkg::*;
#(
    parameter logic [2:0]  CLAIM_ADDR = CLAIM_ADDR_DEF,
    parameter int unsigned RD_LAT     = RD_LAT_DEF,
    parameter int unsigned ID_W       = ID_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            irq,
    input  logic            irq_en,
    output logic            plic_wr_H_rd_L,
    output logic            plic_load,
    output logic [2:0]      plic_addr,
    output logic [31:0]     plic_wdata,
    input  logic [31:0]     plic_rdata,
    input  logic            cpu_req,
    input  logic            cpu_wr,
    input  logic [2:0]      cpu_addr,
    input  logic [31:0]     cpu_wdata,
    output logic [31:0]     cpu_rdata,
    output logic            cpu_ack,
    output logic            trap_req,
    output logic [ID_W-1:0] trap_id,
    input  logic            trap_ack,
    input  logic            trap_done,
    output plic_state_e     dbg_state
);

    plic_state_e     state_q, ret_q;
    logic            rr_last_q, done_pend_q;
    logic            load_q, wr_q, cpu_ack_q, trap_req_q;
    logic [2:0]      addr_q;
    logic [31:0]     wdata_q, cpu_rdata_q;
    logic [ID_W-1:0] trap_id_q;

    logic            claim_ok, cpu_ok, rd_done, tmr_load;
    logic            claim_sample, xfer_sample;
    logic [ID_W-1:0] claim_id;

    // CPU handshake: cpu_req is held until the one-cycle cpu_ack; the request
    // still visible during the ack cycle is the finished one, so it is masked.
    assign claim_ok = irq & irq_en;
    assign cpu_ok   = cpu_req & ~cpu_ack_q;
    assign claim_id = plic_rdata[ID_W-1:0];
    assign tmr_load = (state_q == CLAIM_ISSUE) || (state_q == XFER_ISSUE);

    assign claim_sample = ((state_q == CLAIM_ISSUE) && (RD_LAT == 0)) ||
                          ((state_q == CLAIM_WAIT) && rd_done);
    assign xfer_sample  = ((state_q == XFER_ISSUE) && (wr_q || (RD_LAT == 0))) ||
                          ((state_q == XFER_WAIT) && rd_done);

    plic_rd_timer #(.LAT(RD_LAT)) u_rd_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .done_o (rd_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ret_q       <= IDLE;
            rr_last_q   <= 1'b0;
            done_pend_q <= 1'b0;
            load_q      <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            trap_req_q  <= 1'b0;
            trap_id_q   <= '0;
        end else begin
            load_q    <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_ack_q <= 1'b0;

            if ((state_q == XFER_ISSUE || state_q == XFER_WAIT) &&
                ret_q == SERVICE && trap_done) begin
                done_pend_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (cpu_ok && (!claim_ok || rr_last_q)) begin
                        state_q <= XFER_ISSUE;
                        ret_q   <= IDLE;
                        load_q  <= 1'b1;
                        wr_q    <= cpu_wr;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                    end else if (claim_ok) begin
                        state_q <= CLAIM_ISSUE;
                        load_q  <= 1'b1;
                        addr_q  <= CLAIM_ADDR;
                    end
                end
                CLAIM_ISSUE, CLAIM_WAIT: begin
                    if (!claim_sample) begin
                        state_q <= CLAIM_WAIT;
                    end else if (claim_id != '0) begin
                        state_q    <= PRESENT;
                        trap_req_q <= 1'b1;
                        trap_id_q  <= claim_id;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                PRESENT: begin
                    if (trap_ack) begin
                        state_q    <= SERVICE;
                        trap_req_q <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (cpu_ok) begin
                        state_q <= XFER_ISSUE;
                        ret_q   <= SERVICE;
                        load_q  <= 1'b1;
                        wr_q    <= cpu_wr;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        if (trap_done) begin
                            done_pend_q <= 1'b1;
                        end
                    end else if (trap_done || done_pend_q) begin
                        state_q <= COMPLETE_WR;
                        load_q  <= 1'b1;
                        wr_q    <= 1'b1;
                        addr_q  <= CLAIM_ADDR;
                        wdata_q <= 32'(trap_id_q);
                    end
                end
                COMPLETE_WR: begin
                    state_q     <= IDLE;
                    trap_id_q   <= '0;
                    rr_last_q   <= 1'b1;
                    done_pend_q <= 1'b0;
                end
                XFER_ISSUE, XFER_WAIT: begin
                    if (xfer_sample) begin
                        if (!wr_q) begin
                            cpu_rdata_q <= plic_rdata;
                        end
                        cpu_ack_q <= 1'b1;
                        rr_last_q <= 1'b0;
                        state_q   <= ret_q;
                    end else begin
                        state_q <= XFER_WAIT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign plic_wr_H_rd_L = wr_q;
    assign plic_load      = load_q;
    assign plic_addr      = addr_q;
    assign plic_wdata     = wdata_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign cpu_ack        = cpu_ack_q;
    assign trap_req       = trap_req_q;
    assign trap_id        = trap_id_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_plic_irq_sequencer.sv
// Bench for plic_irq_sequencer: a small controller model behind the register
// port, directed scenarios, then randomized claim/MMIO traffic.
module tb_plic_irq_sequencer;
    import plic_pkg::*;

    localparam int unsigned RD_LAT = 1;
    localparam int unsigned ID_W   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            irq = 1'b0, irq_en = 1'b0;
    logic            cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [2:0]      cpu_addr = '0;
    logic [31:0]     cpu_wdata = '0;
    logic            trap_ack = 1'b0, trap_done = 1'b0;
    logic            plic_wr_H_rd_L, plic_load, cpu_ack, trap_req;
    logic [2:0]      plic_addr;
    logic [31:0]     plic_wdata, plic_rdata, cpu_rdata;
    logic [ID_W-1:0] trap_id;
    plic_state_e     dbg_state;

    int total = 0;
    int bad   = 0;

    // Controller model and reference state
    logic [31:0] plic_mem [8];
    logic [31:0] ref_mem [8];
    logic [31:0] claim_val = '0;
    logic        mem_init = 1'b0;
    logic        rd_vld = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic [31:0] cw_q[$];
    logic [31:0] exp_q[$];
    int          claim_reads = 0;
    logic        overlap_seen = 1'b0;

    always #5 clk = ~clk;

    plic_irq_sequencer #(.CLAIM_ADDR(3'd7), .RD_LAT(RD_LAT), .ID_W(ID_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .irq            (irq),
        .irq_en         (irq_en),
        .plic_wr_H_rd_L (plic_wr_H_rd_L),
        .plic_load      (plic_load),
        .plic_addr      (plic_addr),
        .plic_wdata     (plic_wdata),
        .plic_rdata     (plic_rdata),
        .cpu_req        (cpu_req),
        .cpu_wr         (cpu_wr),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_ack        (cpu_ack),
        .trap_req       (trap_req),
        .trap_id        (trap_id),
        .trap_ack       (trap_ack),
        .trap_done      (trap_done),
        .dbg_state      (dbg_state)
    );

    always @(posedge clk) begin
        rd_vld  <= plic_load & ~plic_wr_H_rd_L;
        rd_addr <= plic_addr;
        if (!mem_init) begin
            for (int i = 0; i < 8; i++) plic_mem[i] <= 32'(i * 6);
            mem_init <= 1'b1;
        end else if (plic_load && plic_wr_H_rd_L) begin
            if (plic_addr == 3'd7) cw_q.push_back(plic_wdata);
            else plic_mem[plic_addr] <= plic_wdata;
        end
        if (plic_load && !plic_wr_H_rd_L && plic_addr == 3'd7) claim_reads++;
        if (plic_load && cpu_ack) overlap_seen <= 1'b1;
    end

    // Data is only valid exactly RD_LAT(=1) cycles after a read strobe.
    assign plic_rdata = !rd_vld ? 32'hDEAD_BEEF :
                        (rd_addr == 3'd7) ? claim_val : plic_mem[rd_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_trap_req();
        int n = 0;
        while (!trap_req && n < 20) begin
            cyc(1);
            n++;
        end
        chk("trap_req_seen", 32'(trap_req), 1);
    endtask

    task automatic rand_xfer();
        logic        w = 1'($urandom_range(0, 1));
        logic [2:0]  a = 3'($urandom_range(0, 6));
        logic [31:0] d = $urandom();
        int          n = 0;
        cpu_req = 1'b1; cpu_wr = w; cpu_addr = a; cpu_wdata = d;
        if (w) ref_mem[a] = d;
        else exp_q.push_back(ref_mem[a]);
        do begin
            cyc(1);
            n++;
        end while (!cpu_ack && n < 20);
        chk("rnd_cpu_ack", 32'(cpu_ack), 1);
        if (cpu_ack && !w) chk("rnd_rdata", cpu_rdata, exp_q.pop_front());
        cpu_req = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        int          base;
        int          id;
        for (int i = 0; i < 8; i++) ref_mem[i] = 32'(i * 6);

        // Reset state
        cyc(2);
        chk("rst_ctl", {plic_load, plic_wr_H_rd_L, plic_addr, cpu_ack, trap_req, trap_id}, 0);
        chk("rst_wdata", plic_wdata, 0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));

        // Basic claim / present / complete, ID 5
        rst = 1'b0; claim_val = 32'd5; irq = 1'b1; irq_en = 1'b1;
        cyc(1);
        chk("t1_claim_strobe", {plic_load, plic_wr_H_rd_L, plic_addr}, {1'b1, 1'b0, 3'd7});
        irq = 1'b0;
        cyc(1);
        chk("t1_no_req_c2", 32'(trap_req), 0);
        cyc(1);
        chk("t1_trap_req", 32'(trap_req), 1);
        chk("t1_trap_id", 32'(trap_id), 5);
        irq_en = 1'b0;
        cyc(3);
        chk("t1_req_held", {trap_req, trap_id}, {1'b1, 4'd5});
        trap_ack = 1'b1; cyc(1); trap_ack = 1'b0;
        chk("t1_req_drop", 32'(trap_req), 0);
        chk("t1_service", 32'(dbg_state), 32'(SERVICE));
        cyc(2);
        chk("t1_no_cw_yet", 32'(cw_q.size()), 0);
        trap_done = 1'b1; cyc(1); trap_done = 1'b0;
        chk("t1_cw_strobe", {plic_load, plic_wr_H_rd_L, plic_addr}, {1'b1, 1'b1, 3'd7});
        chk("t1_cw_wdata", plic_wdata, 5);
        cyc(1);
        chk("t1_idle", 32'(dbg_state), 32'(IDLE));
        chk("t1_id_clear", 32'(trap_id), 0);
        chk("t1_cw_count", 32'(cw_q.size()), 1);
        cw_q.delete();

        // Spurious claim returns 0
        base = claim_reads; claim_val = 32'd0; irq = 1'b1; irq_en = 1'b1;
        cyc(1); irq = 1'b0;
        cyc(2);
        chk("t2_idle", 32'(dbg_state), 32'(IDLE));
        chk("t2_one_claim", 32'(claim_reads), 32'(base + 1));
        cyc(3);
        chk("t2_no_req", 32'(trap_req), 0);
        chk("t2_no_cw", 32'(cw_q.size()), 0);

        // CPU read of addr 3
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 3'd3;
        cyc(1);
        chk("t3_rd_strobe", {plic_load, plic_wr_H_rd_L, plic_addr}, {1'b1, 1'b0, 3'd3});
        cyc(1);
        chk("t3_no_ack_yet", 32'(cpu_ack), 0);
        cyc(1);
        chk("t3_ack", 32'(cpu_ack), 1);
        chk("t3_rdata", cpu_rdata, 32'h12);
        cpu_req = 1'b0;
        cyc(1);
        chk("t3_quiet", {cpu_ack, plic_load}, 0);
        chk("t3_rdata_hold", cpu_rdata, 32'h12);

        // Contention from reset, CPU write in SERVICE, then CPU wins next
        rst = 1'b1; cyc(1); rst = 1'b0;
        claim_val = 32'd9; irq = 1'b1; irq_en = 1'b1;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 3'd2; cpu_wdata = 32'h0000_ABCD;
        cyc(1);
        chk("t4_claim_first", {plic_load, plic_wr_H_rd_L, plic_addr}, {1'b1, 1'b0, 3'd7});
        irq = 1'b0;
        cyc(2);
        chk("t4_req_id", {trap_req, trap_id}, {1'b1, 4'd9});
        chk("t4_no_cpu_in_present", 32'(plic_load), 0);
        trap_ack = 1'b1; cyc(1); trap_ack = 1'b0;
        cyc(1);
        chk("t4_wr_strobe", {plic_load, plic_wr_H_rd_L, plic_addr}, {1'b1, 1'b1, 3'd2});
        chk("t4_wr_data", plic_wdata, 32'h0000_ABCD);
        cyc(1);
        chk("t4_wr_ack", 32'(cpu_ack), 1);
        chk("t4_ack_before_cw", 32'(cw_q.size()), 0);
        cpu_req = 1'b0; ref_mem[2] = 32'h0000_ABCD;
        trap_done = 1'b1; cyc(1); trap_done = 1'b0;
        chk("t4_cw", {plic_load, plic_wr_H_rd_L, plic_addr}, {1'b1, 1'b1, 3'd7});
        chk("t4_cw_wdata", plic_wdata, 9);
        cyc(1);
        irq = 1'b1; claim_val = 32'd0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 3'd2;
        cyc(1);
        chk("t4_cpu_first", {plic_load, plic_wr_H_rd_L, plic_addr}, {1'b1, 1'b0, 3'd2});
        cyc(2);
        chk("t4_rd_ack", 32'(cpu_ack), 1);
        chk("t4_rd_data", cpu_rdata, ref_mem[2]);
        cpu_req = 1'b0;
        cyc(1);
        chk("t4_claim_next", {plic_load, plic_wr_H_rd_L, plic_addr}, {1'b1, 1'b0, 3'd7});
        irq = 1'b0;
        cyc(2);
        chk("t4_idle", 32'(dbg_state), 32'(IDLE));
        chk("t4_cw_count", 32'(cw_q.size()), 1);
        cw_q.delete();

        // trap_done during XFER_WAIT inside SERVICE
        claim_val = 32'd6; irq = 1'b1;
        wait_trap_req();
        irq = 1'b0;
        chk("t5_id", 32'(trap_id), 6);
        trap_ack = 1'b1; cyc(1); trap_ack = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 3'd3;
        cyc(1);
        chk("t5_xfer_issue", 32'(dbg_state), 32'(XFER_ISSUE));
        cyc(1);
        chk("t5_xfer_wait", 32'(dbg_state), 32'(XFER_WAIT));
        trap_done = 1'b1;
        cyc(1);
        trap_done = 1'b0;
        chk("t5_ack", {cpu_ack, plic_load}, {1'b1, 1'b0});
        chk("t5_rdata", cpu_rdata, ref_mem[3]);
        cpu_req = 1'b0;
        cyc(1);
        chk("t5_cw", {plic_load, plic_wr_H_rd_L, plic_addr}, {1'b1, 1'b1, 3'd7});
        chk("t5_cw_wdata", plic_wdata, 6);
        cyc(1);
        chk("t5_cw_count", 32'(cw_q.size()), 1);
        cw_q.delete();

        // Reset during PRESENT
        claim_val = 32'd3; irq = 1'b1;
        wait_trap_req();
        irq = 1'b0;
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("t6_ctl", {plic_load, plic_wr_H_rd_L, plic_addr, cpu_ack, trap_req, trap_id}, 0);
        chk("t6_wdata", plic_wdata, 0);
        chk("t6_rdata", cpu_rdata, 0);
        chk("t6_state", 32'(dbg_state), 32'(IDLE));
        trap_ack = 1'b1; cyc(1); trap_ack = 1'b0;
        trap_done = 1'b1; cyc(1); trap_done = 1'b0;
        cyc(5);
        chk("t6_no_cw", 32'(cw_q.size()), 0);
        chk("t6_no_req", 32'(trap_req), 0);

        // Randomized claims with MMIO traffic before and during service
        for (int k = 0; k < 12; k++) begin
            int n_pre = $urandom_range(0, 2);
            int n_svc = $urandom_range(0, 2);
            for (int j = 0; j < n_pre; j++) rand_xfer();
            id = $urandom_range(1, 14);
            claim_val = 32'(id); irq = 1'b1; irq_en = 1'b1;
            wait_trap_req();
            irq = 1'b0;
            chk("rnd_trap_id", 32'(trap_id), 32'(id));
            cyc($urandom_range(0, 3));
            chk("rnd_req_hold", 32'(trap_req), 1);
            trap_ack = 1'b1; cyc(1); trap_ack = 1'b0;
            for (int j = 0; j < n_svc; j++) rand_xfer();
            trap_done = 1'b1; cyc(1); trap_done = 1'b0;
            cyc(1);
            chk("rnd_cw_count", 32'(cw_q.size()), 1);
            got = (cw_q.size() > 0) ? cw_q[0] : 32'hFFFF_FFFF;
            chk("rnd_cw_data", got, 32'(id));
            cw_q.delete();
        end

        chk("no_ack_with_load", 32'(overlap_seen), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plic_irq_sequencer.md
Name: plic_irq_sequencer

Overview:
- Sequences the interrupt controller's single register port on behalf of the hart, and shares that port with ordinary CPU MMIO accesses.
- On a raised interrupt line, performs the claim read, presents the claimed ID to the trap unit and waits for the handler to finish. It then performs the complete write.
- Sits between the CPU load/store path, the trap unit and the interrupt controller's register interface (wr_H_rd_L/load/addr/wdata/rdata).

Parameters:
- CLAIM_ADDR, 3'd7, register-port address of the claim/complete register.
- RD_LAT, 1, cycles from a read strobe (load=1, wr_H_rd_L=0) to rdata valid; legal 0..3.
- ID_W, 4, width of the interrupt ID.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- irq  in  1  interrupt request from the interrupt controller (level)
- irq_en  in  1  global interrupt enable from the trap unit (mstatus.MIE)
- plic_wr_H_rd_L  out  1  register-port direction, 1=write
- plic_load  out  1  register-port strobe, one cycle per access
- plic_addr  out  3  register-port address
- plic_wdata  out  32  register-port write data
- plic_rdata  in  32  register-port read data
- cpu_req  in  1  CPU MMIO request, held until cpu_ack
- cpu_wr  in  1  CPU request is a write
- cpu_addr  in  3  CPU register address
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- trap_req  out  1  interrupt pending to the trap unit
- trap_id  out  ID_W  claimed ID, stable while trap_req=1 and through SERVICE
- trap_ack  in  1  trap unit has taken the interrupt
- trap_done  in  1  one-cycle pulse when the handler has executed mret

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE; all outputs are 0; rr_last=0; the return-state register is IDLE.
- The strobe is asserted only in XFER_ISSUE, CLAIM_ISSUE and COMPLETE_WR. Otherwise plic_load=0 and the addr/wdata/wr fields are 0.
- States:
  - IDLE: go to CLAIM_ISSUE or XFER_ISSUE per arbitration; otherwise stay.
  - CLAIM_ISSUE: plic_load=1, wr=0, addr=CLAIM_ADDR, for one cycle, then go to CLAIM_WAIT.
  - CLAIM_WAIT: count RD_LAT cycles, then sample plic_rdata[ID_W-1:0].
    - ID=0 (spurious): go to IDLE with no trap_req and no complete.
    - ID≠0: latch trap_id and go to PRESENT.
    - RD_LAT=0: sample rdata in the CLAIM_ISSUE cycle and skip CLAIM_WAIT.
  - PRESENT: trap_req=1 until trap_ack is sampled high. trap_req drops in the following cycle and the FSM goes to SERVICE.
  - SERVICE: wait for trap_done, then go to COMPLETE_WR. CPU MMIO is allowed here (the handler may touch controller registers).
  - COMPLETE_WR: plic_load=1, wr=1, addr=CLAIM_ADDR, wdata={zero-pad, trap_id}, for one cycle. Then trap_id clears to 0, state goes to IDLE and rr_last=1.
  - XFER_ISSUE: drive cpu_wr/cpu_addr/cpu_wdata onto the port with plic_load=1 for one cycle.
    - Write: cpu_ack in the next cycle.
    - Read: go to XFER_WAIT.
  - XFER_WAIT: after RD_LAT cycles, cpu_rdata=plic_rdata with cpu_ack=1 for one cycle.
  - After cpu_ack: return to the saved state (IDLE or SERVICE) and set rr_last=0.
- Arbitration in IDLE (claim is eligible when irq&irq_en):
  - Only one eligible: grant it.
  - Both: claim wins if rr_last=0, CPU wins if rr_last=1.
- Arbitration in SERVICE: cpu_req is granted immediately; trap_done pending during an XFER is latched and honoured on return.
- trap_done outside SERVICE is ignored. trap_ack outside PRESENT is ignored.
- irq dropping during CLAIM_WAIT has no effect; the claimed rdata decides the outcome.
- irq_en deasserting during PRESENT: trap_req stays high; the claim is already owned.
- Only one interrupt is in service at a time; no nesting.
- cpu_rdata holds its last value between acks. cpu_ack never coincides with plic_load.
- rst mid-operation aborts immediately with no complete write. Software re-initialises the controller.

Decomposition:
- Shared package plic_pkg holds: the state enum (IDLE, CLAIM_ISSUE, CLAIM_WAIT, PRESENT, SERVICE, COMPLETE_WR, XFER_ISSUE, XFER_WAIT), the CLAIM_ADDR default and the ID_W default.
- One natural sub-module: plic_rd_timer, a loadable RD_LAT down-counter with a done flag, shared by CLAIM_WAIT and XFER_WAIT.

Test Plan:
- irq=1, irq_en=1, RD_LAT=1, rdata=5 -> expected:
  - read strobe at addr 7 in cycle 1;
  - trap_req=1, trap_id=5 from cycle 3;
  - after trap_ack then trap_done, one write with addr=7, wdata=5; back to IDLE.
- Claim read returns 0 -> no trap_req, no write strobe, IDLE after CLAIM_WAIT.
- cpu_req read of addr 3 with rdata=0x12, and irq held low -> single read strobe; cpu_ack with cpu_rdata=0x12 after RD_LAT+1 cycles.
- irq and cpu_req both asserted from reset, rr_last=0 -> claim first. Then CPU write during SERVICE gets cpu_ack before trap_done completion. Next contention goes to CPU first.
- trap_done pulsed during XFER_WAIT in SERVICE -> complete write issued right after cpu_ack, with wdata equal to the claimed ID.
- rst=1 during PRESENT -> next cycle all outputs are 0 and state is IDLE; no complete write ever issued for that ID.
